// File: rtl/wb_stage.sv
// Write-back stage: M/W pipeline register, load extension and write-back
// mux feeding the register file's single write port.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          LOG_EN   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] M_pc,
    input  logic [4:0]  M_reg_addr,
    input  logic [2:0]  M_wb_sel,
    input  logic [2:0]  M_load_type,
    input  logic [31:0] M_alu_out,
    input  logic [31:0] M_mem_rdata,
    input  logic [1:0]  M_mem_off,
    input  logic [31:0] M_mdu_out,
    input  logic [31:0] M_cp0_out,
    output logic [31:0] W_pc,
    output logic [4:0]  W_reg_addr,
    output logic [31:0] W_reg_data,
    output logic [31:0] W_wr_count
);

    localparam logic [2:0] SEL_ALU = 3'd0;
    localparam logic [2:0] SEL_MEM = 3'd1;
    localparam logic [2:0] SEL_PC8 = 3'd2;
    localparam logic [2:0] SEL_MDU = 3'd3;
    localparam logic [2:0] SEL_CP0 = 3'd4;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    // Picks the addressed half/byte of the aligned read word and extends it.
    // off[0] is ignored for halfwords; misaligned accesses never reach here.
    // Reserved load types fall back to a full word.
    function automatic logic [31:0] load_ext(
        input logic [2:0]  load_type,
        input logic [1:0]  off,
        input logic [31:0] word
    );
        logic [15:0] half;
        logic [7:0]  byte_v;
        half = off[1] ? word[31:16] : word[15:0];
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        case (load_type)
            LD_LH:   load_ext = {{16{half[15]}}, half};
            LD_LHU:  load_ext = {16'h0000, half};
            LD_LB:   load_ext = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  load_ext = {24'h00_0000, byte_v};
            default: load_ext = word;
        endcase
    endfunction

    // ---- M/W pipeline register (stage p0) ----
    logic [31:0] pc_p0;
    logic [4:0]  reg_addr_p0;
    logic [2:0]  wb_sel_p0;
    logic [2:0]  load_type_p0;
    logic [31:0] alu_p0;
    logic [31:0] mem_p0;
    logic [1:0]  off_p0;
    logic [31:0] mdu_p0;
    logic [31:0] cp0_p0;
    logic [31:0] wr_count_p0;
    logic        vld_p0;
    logic [31:0] reg_data_p0;

    // A register address of zero marks a bubble or a discarded result.
    assign vld_p0 = (reg_addr_p0 != 5'd0);

    // Capture M every cycle; reset and flush both load a bubble.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            pc_p0        <= RESET_PC;
            reg_addr_p0  <= 5'd0;
            wb_sel_p0    <= SEL_ALU;
            load_type_p0 <= LD_LW;
            alu_p0       <= 32'h0;
            mem_p0       <= 32'h0;
            off_p0       <= 2'd0;
            mdu_p0       <= 32'h0;
            cp0_p0       <= 32'h0;
        end else begin
            pc_p0        <= M_pc;
            reg_addr_p0  <= M_reg_addr;
            wb_sel_p0    <= M_wb_sel;
            load_type_p0 <= M_load_type;
            alu_p0       <= M_alu_out;
            mem_p0       <= M_mem_rdata;
            off_p0       <= M_mem_off;
            mdu_p0       <= M_mdu_out;
            cp0_p0       <= M_cp0_out;
        end
    end

    // Count writes retiring out of W; a flush still lets the held write retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_p0 <= 32'h0;
        end else if (vld_p0) begin
            wr_count_p0 <= wr_count_p0 + 32'd1;
        end
    end

    // Write-back source mux, with register 0 always reading back as zero.
    always_comb begin
        reg_data_p0 = 32'h0;
        case (wb_sel_p0)
            SEL_ALU: reg_data_p0 = alu_p0;
            SEL_MEM: reg_data_p0 = load_ext(load_type_p0, off_p0, mem_p0);
            SEL_PC8: reg_data_p0 = pc_p0 + 32'd8;
            SEL_MDU: reg_data_p0 = mdu_p0;
            SEL_CP0: reg_data_p0 = cp0_p0;
            default: reg_data_p0 = 32'h0;
        endcase
        if (!vld_p0) begin
            reg_data_p0 = 32'h0;
        end
    end

    assign W_pc       = pc_p0;
    assign W_reg_addr = reg_addr_p0;
    assign W_reg_data = reg_data_p0;
    assign W_wr_count = wr_count_p0;

`ifndef SYNTHESIS
    generate
        if (LOG_EN != 0) begin : g_log
            // Simulation write log, one line per retiring register write.
            always_ff @(posedge clk) begin
                if (!reset && vld_p0) begin
                    $display("@%h: $%d <= %h", pc_p0, reg_addr_p0, reg_data_p0);
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] M_pc;
    logic [4:0]  M_reg_addr;
    logic [2:0]  M_wb_sel;
    logic [2:0]  M_load_type;
    logic [31:0] M_alu_out;
    logic [31:0] M_mem_rdata;
    logic [1:0]  M_mem_off;
    logic [31:0] M_mdu_out;
    logic [31:0] M_cp0_out;
    logic [31:0] W_pc;
    logic [4:0]  W_reg_addr;
    logic [31:0] W_reg_data;
    logic [31:0] W_wr_count;

    int n_cmp;
    int n_err;
    logic [31:0] exp_cnt;
    logic [4:0]  held_addr;

    wb_stage #(.RESET_PC(RST_PC), .LOG_EN(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .M_pc       (M_pc),
        .M_reg_addr (M_reg_addr),
        .M_wb_sel   (M_wb_sel),
        .M_load_type(M_load_type),
        .M_alu_out  (M_alu_out),
        .M_mem_rdata(M_mem_rdata),
        .M_mem_off  (M_mem_off),
        .M_mdu_out  (M_mdu_out),
        .M_cp0_out  (M_cp0_out),
        .W_pc       (W_pc),
        .W_reg_addr (W_reg_addr),
        .W_reg_data (W_reg_data),
        .W_wr_count (W_wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge, update the expected write count from the write the
    // bench believes W held at that edge, then check all W outputs.
    task automatic step(input string tag, input logic [4:0] e_addr,
                        input logic [31:0] e_data, input logic [31:0] e_pc);
        @(posedge clk);
        if (reset) exp_cnt = 32'h0;
        else if (held_addr != 5'd0) exp_cnt = exp_cnt + 32'd1;
        held_addr = e_addr;
        #1;
        chk({tag, ".addr"},  {27'h0, W_reg_addr}, {27'h0, e_addr});
        chk({tag, ".data"},  W_reg_data, e_data);
        chk({tag, ".pc"},    W_pc, e_pc);
        chk({tag, ".count"}, W_wr_count, exp_cnt);
    endtask

    task automatic drive(input logic [4:0] a, input logic [2:0] sel, input logic [2:0] lt,
                         input logic [1:0] off, input logic [31:0] alu, input logic [31:0] pc);
        M_reg_addr  = a;
        M_wb_sel    = sel;
        M_load_type = lt;
        M_mem_off   = off;
        M_alu_out   = alu;
        M_pc        = pc;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_cnt = 32'h0;
        held_addr = 5'd0;
        reset = 1'b1;
        flush = 1'b0;
        M_mem_rdata = 32'h80FF_7F01;
        M_mdu_out = 32'hAAAA_5555;
        M_cp0_out = 32'hC0C0_0C0C;
        drive(5'd0, 3'd0, 3'd0, 2'd0, 32'h0, 32'h0);

        step("reset", 5'd0, 32'h0, RST_PC);
        reset = 1'b0;

        drive(5'd5, 3'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0000_3000);
        step("alu", 5'd5, 32'h1234_5678, 32'h0000_3000);

        drive(5'd2, 3'd1, 3'd3, 2'd3, 32'h0, 32'h0000_3004);
        step("lb3", 5'd2, 32'hFFFF_FF80, 32'h0000_3004);
        drive(5'd2, 3'd1, 3'd4, 2'd3, 32'h0, 32'h0000_3008);
        step("lbu3", 5'd2, 32'h0000_0080, 32'h0000_3008);
        drive(5'd2, 3'd1, 3'd3, 2'd0, 32'h0, 32'h0000_300C);
        step("lb0", 5'd2, 32'h0000_0001, 32'h0000_300C);
        drive(5'd2, 3'd1, 3'd4, 2'd1, 32'h0, 32'h0000_3020);
        step("lbu1", 5'd2, 32'h0000_007F, 32'h0000_3020);
        drive(5'd2, 3'd1, 3'd1, 2'd2, 32'h0, 32'h0000_3024);
        step("lh2", 5'd2, 32'hFFFF_80FF, 32'h0000_3024);
        drive(5'd2, 3'd1, 3'd1, 2'd3, 32'h0, 32'h0000_3028);
        step("lh3", 5'd2, 32'hFFFF_80FF, 32'h0000_3028);
        drive(5'd2, 3'd1, 3'd2, 2'd0, 32'h0, 32'h0000_302C);
        step("lhu0", 5'd2, 32'h0000_7F01, 32'h0000_302C);
        drive(5'd2, 3'd1, 3'd0, 2'd2, 32'h0, 32'h0000_3030);
        step("lw", 5'd2, 32'h80FF_7F01, 32'h0000_3030);
        drive(5'd2, 3'd1, 3'd6, 2'd3, 32'h0, 32'h0000_3034);
        step("ld_rsvd", 5'd2, 32'h80FF_7F01, 32'h0000_3034);

        drive(5'd31, 3'd2, 3'd0, 2'd0, 32'h0, 32'h0000_3010);
        step("pc8", 5'd31, 32'h0000_3018, 32'h0000_3010);
        drive(5'd31, 3'd2, 3'd0, 2'd0, 32'h0, 32'hFFFF_FFFC);
        step("pc8_wrap", 5'd31, 32'h0000_0004, 32'hFFFF_FFFC);

        drive(5'd4, 3'd3, 3'd0, 2'd0, 32'h0, 32'h0000_3040);
        step("mdu", 5'd4, 32'hAAAA_5555, 32'h0000_3040);
        drive(5'd4, 3'd4, 3'd0, 2'd0, 32'h0, 32'h0000_3044);
        step("cp0", 5'd4, 32'hC0C0_0C0C, 32'h0000_3044);

        drive(5'd0, 3'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0000_3048);
        step("r0", 5'd0, 32'h0, 32'h0000_3048);
        drive(5'd3, 3'd6, 3'd0, 2'd0, 32'h5555_5555, 32'h0000_304C);
        step("sel_rsvd", 5'd3, 32'h0, 32'h0000_304C);

        // W holds the reg-3 write while a flush edge arrives.
        drive(5'd7, 3'd0, 3'd0, 2'd0, 32'h0000_0077, 32'h0000_4000);
        flush = 1'b1;
        step("flush", 5'd0, 32'h0, RST_PC);
        flush = 1'b0;
        drive(5'd0, 3'd0, 3'd0, 2'd0, 32'h0, 32'h0000_4004);
        step("idle", 5'd0, 32'h0, 32'h0000_4004);

        drive(5'd9, 3'd0, 3'd0, 2'd0, 32'h0000_0099, 32'h0000_4008);
        step("pre_rf", 5'd9, 32'h0000_0099, 32'h0000_4008);
        reset = 1'b1;
        flush = 1'b1;
        step("rst_flush", 5'd0, 32'h0, RST_PC);
        reset = 1'b0;
        flush = 1'b0;

        for (int i = 1; i <= 10; i++) begin
            drive(5'(i), 3'd0, 3'd0, 2'd0, 32'(i * 16), 32'(32'h5000 + 4 * i));
            step("burst", 5'(i), 32'(i * 16), 32'(32'h5000 + 4 * i));
        end
        drive(5'd0, 3'd0, 3'd0, 2'd0, 32'h0, 32'h0000_6000);
        step("burst_end", 5'd0, 32'h0, 32'h0000_6000);
        chk("count10", W_wr_count, 32'd10);
        reset = 1'b1;
        step("burst_rst", 5'd0, 32'h0, RST_PC);
        chk("count0", W_wr_count, 32'd0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
